// File: rtl/packer_pkg.sv
// rtl/packer_pkg.sv - shared types and helpers for the operand packer
// Purpose : precision codes, packer state enum, element-width helpers.
// Ports   : none (package).
// Config  : PACKER_SAT_EN is consumed only by elem_narrow.
`timescale 1ns/1ps
package packer_pkg;

  localparam logic [1:0] PREC_2B = 2'd0;
  localparam logic [1:0] PREC_4B = 2'd1;
  localparam logic [1:0] PREC_8B = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Code 3 is reserved and behaves as 8-bit.
  function automatic logic [3:0] elem_width(input logic [1:0] prec);
    case (prec)
      PREC_2B: return 4'd2;
      PREC_4B: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [4:0] elems_per_word(input logic [1:0] prec);
    case (prec)
      PREC_2B: return 5'd16;
      PREC_4B: return 5'd8;
      default: return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/elem_narrow.sv
// rtl/elem_narrow.sv - combinational 8-bit to W-bit operand narrowing
// Purpose : narrow a two's complement byte to the precision's element width,
//           zero-extended back to 8 bits.
// Ports   : prec    in  2  precision code selecting W
//           in_data in  8  operand
//           narrow  out 8  narrowed element in the low W bits, upper bits 0
// Config  : PACKER_SAT_EN defined -> saturate to the signed W-bit range,
//           undefined -> truncate to the low W bits.
`timescale 1ns/1ps
module elem_narrow
  import packer_pkg::*;
(
  input  logic [1:0] prec,
  input  logic [7:0] in_data,
  output logic [7:0] narrow
);

  always_comb begin
    narrow = in_data;
`ifdef PACKER_SAT_EN
    case (prec)
      PREC_2B: begin
        if ($signed(in_data) > 8'sd1)       narrow = 8'h01;
        else if ($signed(in_data) < -8'sd2) narrow = 8'h02;
        else                                narrow = {6'b0, in_data[1:0]};
      end
      PREC_4B: begin
        if ($signed(in_data) > 8'sd7)       narrow = 8'h07;
        else if ($signed(in_data) < -8'sd8) narrow = 8'h08;
        else                                narrow = {4'b0, in_data[3:0]};
      end
      default: narrow = in_data;
    endcase
`else
    case (prec)
      PREC_2B: narrow = {6'b0, in_data[1:0]};
      PREC_4B: narrow = {4'b0, in_data[3:0]};
      default: narrow = in_data;
    endcase
`endif
  end

endmodule

// File: rtl/operand_packer_32bit.sv
// rtl/operand_packer_32bit.sv - packs narrowed operands LSB-first into 32-bit words
// Purpose : accept one byte operand per cycle, narrow it to 2/4/8 bits and
//           pack into 32-bit words behind a one-entry output register.
// Ports   : clk, reset (async, active-high)
//           prec[1:0], in_data[7:0], in_valid, in_last, in_ready  - operand input
//           out_data[31:0], out_count[4:0], out_last, out_valid, out_ready - word output
// Config  : PACKER_SAT_EN selects saturating narrowing (see elem_narrow).
`timescale 1ns/1ps
module operand_packer_32bit
  import packer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IN_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        prec,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_count,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t      state, state_n;
  logic [31:0] acc, acc_n;
  logic [4:0]  acc_cnt, cnt_n;
  logic        acc_last, last_n;
  logic [1:0]  acc_prec, prec_n;

  logic        load_out;
  logic [31:0] load_data;
  logic [4:0]  load_count;
  logic        load_last;

  logic [1:0]  cur_prec;
  logic [7:0]  elem;
  logic [8:0]  offset;
  logic [31:0] word;
  logic [4:0]  cnt_inc;
  logic        in_fire;
  logic        out_free;

  // The first element of a word takes the live prec; later ones use the latched copy.
  assign cur_prec = (state == EMPTY) ? prec : acc_prec;

  elem_narrow u_narrow (
    .prec    (cur_prec),
    .in_data (in_data),
    .narrow  (elem)
  );

  assign offset   = 9'(acc_cnt) * 9'(elem_width(cur_prec));
  assign word     = acc | ({24'b0, elem} << offset);
  assign cnt_inc  = acc_cnt + 5'd1;
  assign in_ready = (state != FULL);
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    cnt_n      = acc_cnt;
    last_n     = acc_last;
    prec_n     = acc_prec;
    load_out   = 1'b0;
    load_data  = acc;
    load_count = acc_cnt;
    load_last  = acc_last;
    case (state)
      EMPTY, FILL: begin
        if (in_fire) begin
          prec_n = cur_prec;
          if (cnt_inc == elems_per_word(cur_prec) || in_last) begin
            if (out_free) begin
              load_out   = 1'b1;
              load_data  = word;
              load_count = cnt_inc;
              load_last  = in_last;
              acc_n      = '0;
              cnt_n      = '0;
              last_n     = 1'b0;
              state_n    = EMPTY;
            end else begin
              // Completed word parks in the accumulator until the output frees.
              acc_n   = word;
              cnt_n   = cnt_inc;
              last_n  = in_last;
              state_n = FULL;
            end
          end else begin
            acc_n   = word;
            cnt_n   = cnt_inc;
            state_n = FILL;
          end
        end
      end
      FULL: begin
        if (out_free) begin
          load_out = 1'b1;
          acc_n    = '0;
          cnt_n    = '0;
          last_n   = 1'b0;
          state_n  = EMPTY;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      acc       <= '0;
      acc_cnt   <= '0;
      acc_last  <= 1'b0;
      acc_prec  <= PREC_2B;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      acc_cnt  <= cnt_n;
      acc_last <= last_n;
      acc_prec <= prec_n;
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
        out_count <= load_count;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_packer_32bit.sv
// tb/tb_operand_packer_32bit.sv - scoreboard bench for operand_packer_32bit
`timescale 1ns/1ps
module tb_operand_packer_32bit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  prec;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [4:0]  out_count;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  operand_packer_32bit dut (
    .clk       (clk),
    .reset     (reset),
    .prec      (prec),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  count;
    logic        last;
  } word_t;

  word_t       exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  bit          use_model = 1'b0;
  bit          rand_on   = 1'b0;
  logic [31:0] m_word = '0;
  int          m_cnt  = 0;
  logic [1:0]  m_prec = 2'd0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int tb_width(input logic [1:0] p);
    return (p == 2'd0) ? 2 : (p == 2'd1) ? 4 : 8;
  endfunction

  function automatic logic [31:0] tb_narrow(input logic [7:0] d, input logic [1:0] p);
    int w;
    int v;
    logic [31:0] mask;
    w = tb_width(p);
    v = int'($signed(d));
`ifdef PACKER_SAT_EN
    if (v > (1 << (w - 1)) - 1) v = (1 << (w - 1)) - 1;
    if (v < -(1 << (w - 1)))    v = -(1 << (w - 1));
`endif
    mask = (32'd1 << w) - 32'd1;
    return 32'(v) & mask;
  endfunction

  task automatic push_exp(input logic [31:0] d, input logic [4:0] c, input logic l);
    word_t e;
    e.data = d; e.count = c; e.last = l;
    exp_q.push_back(e);
  endtask

  // Drive one operand and hold it until accepted; the reference model tracks every accept.
  task automatic send(input logic [1:0] p, input logic [7:0] d, input logic l);
    int t;
    int w;
    word_t e;
    t = 0;
    prec = p; in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      check("in_ready_timeout", 32'(t), 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (m_cnt == 0) m_prec = p;
    w = tb_width(m_prec);
    m_word = m_word | (tb_narrow(d, m_prec) << (m_cnt * w));
    m_cnt++;
    if (m_cnt == 32 / w || l) begin
      if (use_model) begin
        e.data = m_word; e.count = 5'(m_cnt); e.last = l;
        exp_q.push_back(e);
      end
      m_word = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("out_data",  out_data,         e.data);
        check("out_count", 32'(out_count),   32'(e.count));
        check("out_last",  32'(out_last),    32'(e.last));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; prec = 2'd0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // 8-bit packing and one-cycle latency
    push_exp(32'h44332211, 5'd4, 1'b0);
    send(2'd2, 8'h11, 1'b0);
    send(2'd2, 8'h22, 1'b0);
    send(2'd2, 8'h33, 1'b0);
    check("t1_not_yet_valid", 32'(out_valid), 32'd0);
    send(2'd2, 8'h44, 1'b0);
    check("t1_latency", 32'(out_valid), 32'd1);

    // 4-bit and 2-bit packing
    push_exp(32'h87654321, 5'd8, 1'b0);
    for (int i = 1; i <= 8; i++) send(2'd1, 8'(i), 1'b0);
    push_exp(32'hE4E4E4E4, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) send(2'd0, 8'(i % 4), 1'b0);

    // in_last flush, restart at element 0, in_last on the Nth element
    push_exp(32'h0000BBAA, 5'd2, 1'b1);
    send(2'd2, 8'hAA, 1'b0);
    send(2'd2, 8'hBB, 1'b1);
    push_exp(32'h04030201, 5'd4, 1'b0);
    for (int i = 1; i <= 4; i++) send(2'd2, 8'(i), 1'b0);
    push_exp(32'h08070605, 5'd4, 1'b1);
    for (int i = 5; i <= 8; i++) send(2'd2, 8'(i), i == 8);
    wait_drain();

    // backpressure: one word in the output register, one parked in FULL
    out_ready = 1'b0;
    push_exp(32'h14131211, 5'd4, 1'b0);
    push_exp(32'h18171615, 5'd4, 1'b0);
    for (int i = 1; i <= 8; i++) send(2'd2, 8'(8'h10 + i), 1'b0);
    check("bp_in_ready_full", 32'(in_ready),  32'd0);
    check("bp_out_valid",     32'(out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_data",     out_data,       32'h14131211);
    check("bp_hold_in_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_word2_loaded",  out_data,       32'h18171615);
    check("bp_in_ready_back", 32'(in_ready),  32'd1);
    wait_drain();

    // asynchronous reset with a pending word and a partial accumulator
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(2'd2, 8'hF0 + 8'(i), 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_data",  out_data,       32'd0);
    exp_q.delete();
    m_word = '0; m_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    push_exp(32'h0D0C0B0A, 5'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(2'd2, 8'h0A + 8'(i), 1'b0);
    wait_drain();

    // narrowing of signed values at 4-bit precision
`ifdef PACKER_SAT_EN
    push_exp(32'h3210E587, 5'd8, 1'b0);
`else
    push_exp(32'h3210E50F, 5'd8, 1'b0);
`endif
    send(2'd1, 8'h7F, 1'b0); send(2'd1, 8'h80, 1'b0);
    send(2'd1, 8'h05, 1'b0); send(2'd1, 8'hFE, 1'b0);
    send(2'd1, 8'h00, 1'b0); send(2'd1, 8'h01, 1'b0);
    send(2'd1, 8'h02, 1'b0); send(2'd1, 8'h03, 1'b0);
    wait_drain();

    // random precision changes, in_last and backpressure against the model
    use_model = 1'b1;
    rand_on   = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          if (rand_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 80; i++)
      send(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 7) == 0);
    send(2'd2, 8'h5A, 1'b1);
    rand_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
